uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_cnt.sv | 34 +++
 rtl/uart_tx_cfg.sv | 154 +++++++++++++++
 tb/tb_uart_tx_cfg.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and parity-mode codes.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, pulses tick_o on the
// last cycle of each bit period and restarts from zero on clr_i (state entry).
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DATA_W data bits LSB first, optional
// parity (compiled in only with UART_TX_PARITY_EN), STOP_BITS stop bits.
// Handshake: a word is taken on a rising edge where din_valid && din_ready;
// din_ready is high only in IDLE, so din_valid during a frame is ignored.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_MODE  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              tx,
  output logic              busy,
  output uart_state_e       state_dbg_o
);

  localparam logic [3:0] LAST_BIT  = 4'(DATA_W - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  uart_state_e       state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [3:0]        bit_q, bit_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              tick;
  logic              accept;
  logic              par_bit;

  assign accept = (state_q == IDLE) && din_valid && ready_q;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_ON = (PARITY_MODE != PAR_NONE);
  logic par_q;

  always_ff @(posedge clk) begin
    if (rst)         par_q <= 1'b0;
    else if (accept) par_q <= (^din) ^ (PARITY_MODE == PAR_ODD);
  end

  assign par_bit = par_q;
`else
  // Parity support is not built; the mode parameter has no effect here.
  localparam bit PAR_ON = 1'b0 && (PARITY_MODE != PAR_NONE);
  assign par_bit = 1'b0;
`endif

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_d != state_q),
    .en_i   (state_q != IDLE),
    .tick_o (tick)
  );

  // Outputs are registered from the next-state values, so tx leads state by nothing.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    case (state_q)
      IDLE: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        if (accept) begin
          state_d = START;
          shreg_d = din;
          bit_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          tx_d    = shreg_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q == LAST_BIT) begin
            bit_d = '0;
            if (PAR_ON) begin
              state_d = PARITY;
              tx_d    = par_bit;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 4'd1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_q == LAST_STOP) begin
            state_d = IDLE;
            bit_d   = '0;
            busy_d  = 1'b0;
            ready_d = 1'b1;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign tx          = tx_q;
  assign busy        = busy_q;
  assign din_ready   = ready_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: unit 0 = 8N1-style (even parity when built), unit 1 = two
// stop bits (odd parity when built); both 4 clocks per bit.
module tb_uart_tx_cfg;
  import uart_pkg::*;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din_w [2];
  logic [1:0]  val_w;
  logic [1:0]  rdy_w, tx_w, busy_w;
  uart_state_e st_a, st_b;

  int n_vec = 0;
  int n_err = 0;
  // Record: [24] unit, [23] aborted, [22:21] idle gap (0 = unchecked), [20:16] bits, [15:0] tx bits
  logic [24:0] exp_q [$];

  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_MODE(1)) dut_a (
    .clk(clk), .rst(rst), .din(din_w[0]), .din_valid(val_w[0]), .din_ready(rdy_w[0]),
    .tx(tx_w[0]), .busy(busy_w[0]), .state_dbg_o(st_a)
  );

  uart_tx_cfg #(.DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_MODE(2)) dut_b (
    .clk(clk), .rst(rst), .din(din_w[1]), .din_valid(val_w[1]), .din_ready(rdy_w[1]),
    .tx(tx_w[1]), .busy(busy_w[1]), .state_dbg_o(st_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [24:0] mk(input bit u, input logic [7:0] w, input bit par,
                                     input int stops, input int gap, input bit ab);
    logic [15:0] b;
    int n;
    b = '0;
    for (int i = 0; i < 8; i++) b[1+i] = w[i];
    n = 9;
    if (PEN) begin
      b[n] = par;
      n++;
    end
    for (int s = 0; s < stops; s++) begin
      b[n] = 1'b1;
      n++;
    end
    return {u, ab, 2'(gap), 5'(n), b};
  endfunction

  task automatic monitor(input int d);
    logic [24:0] rec;
    int c, err, idle_c, nb;
    bit infr;
    rec = '0; c = 0; err = 0; idle_c = 0; infr = 0;
    forever begin
      @(negedge clk);
      if (!infr && busy_w[d]) begin
        infr = 1; c = 0; err = 0;
        if (exp_q.size() == 0) begin
          chk("unexpected frame", 32'd1, 32'd0);
          rec = 25'd0;
          rec[23] = 1'b1;
        end else begin
          rec = exp_q.pop_front();
          chk("frame unit", d, {31'd0, rec[24]});
          if (rec[22:21] != 2'd0) chk("idle gap", idle_c, {30'd0, rec[22:21]});
        end
      end
      if (infr) begin
        nb = int'(rec[20:16]);
        if (busy_w[d]) begin
          if (c < nb * CPB && tx_w[d] !== rec[c / CPB]) err++;
          c++;
        end else begin
          if (!rec[23]) chk("frame length", c, nb * CPB);
          chk("frame bits", err, 0);
          infr = 0;
          idle_c = 1;
        end
      end else if (!busy_w[d]) begin
        idle_c++;
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic send(input int d, input logic [7:0] w);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy_w[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rdy_w[d]) begin
      chk("ready timeout", rdy_w[d], 1);
    end else begin
      din_w[d] = w;
      val_w[d] = 1'b1;
      @(posedge clk);
      #1 val_w[d] = 1'b0;
    end
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while (busy_w[d] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy_w[d]) chk("idle timeout", busy_w[d], 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    val_w = '0;
    din_w[0] = 8'h00;
    din_w[1] = 8'h00;
    #(200000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // A word offered during reset must not start a frame.
    #1;
    din_w[0] = 8'h3C;
    val_w[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset tx", tx_w[0], 1);
    chk("reset busy", busy_w[0], 0);
    chk("reset ready", rdy_w[0], 0);
    chk("reset state", st_a, IDLE);
    val_w[0] = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("ready after reset", rdy_w[0], 1);
    chk("busy after reset", busy_w[0], 0);
    repeat ($urandom_range(1, 4)) @(negedge clk);

    exp_q.push_back(mk(0, 8'hA5, 1'b0, 1, 0, 0));
    send(0, 8'hA5);
    wait_idle(0);

    exp_q.push_back(mk(0, 8'h07, 1'b1, 1, 0, 0));
    send(0, 8'h07);
    wait_idle(0);

    exp_q.push_back(mk(1, 8'h07, 1'b0, 2, 0, 0));
    send(1, 8'h07);
    wait_idle(1);

    // Back-to-back with din_valid held: one idle-high cycle between frames.
    exp_q.push_back(mk(1, 8'h55, 1'b1, 2, 0, 0));
    exp_q.push_back(mk(1, 8'hAA, 1'b1, 2, 1, 0));
    @(negedge clk);
    din_w[1] = 8'h55;
    val_w[1] = 1'b1;
    @(posedge clk);
    #1 din_w[1] = 8'hAA;
    n = 0;
    @(negedge clk);
    while (!rdy_w[1] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("b2b ready", rdy_w[1], 1);
    @(posedge clk);
    #1 val_w[1] = 1'b0;
    wait_idle(1);

    // din_valid pulse during DATA must be ignored.
    exp_q.push_back(mk(0, 8'h00, 1'b0, 1, 0, 0));
    send(0, 8'h00);
    repeat (10) @(negedge clk);
    chk("ready in data", rdy_w[0], 0);
    chk("state in data", st_a, DATA);
    din_w[0] = 8'hFF;
    val_w[0] = 1'b1;
    @(negedge clk);
    val_w[0] = 1'b0;
    wait_idle(0);

    // Reset mid-DATA aborts the frame.
    exp_q.push_back(mk(0, 8'h3C, 1'b0, 1, 0, 1));
    send(0, 8'h3C);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset tx", tx_w[0], 1);
    chk("midreset busy", busy_w[0], 0);
    chk("midreset ready", rdy_w[0], 0);
    @(negedge clk);
    chk("midreset ready next", rdy_w[0], 1);
    repeat (2) @(negedge clk);

    exp_q.push_back(mk(0, 8'h5A, 1'b0, 1, 0, 0));
    send(0, 8'h5A);
    wait_idle(0);

    repeat (5) @(negedge clk);
    chk("queue drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
